// File: rtl/sdrc_rr_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller user port.
// One command strobe per burst; write data is streamed and read beats are steered to the owner.
module sdrc_rr_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int GUARD  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_wdata_req,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rd_valid,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LEN_W-1:0]  p1_len,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_wdata_req,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rd_valid,
  output logic              p1_done,
  input  logic              sdrc_init_done,
  input  logic              sdrc_busy_n,
  input  logic              sdrc_rd_valid,
  input  logic [DATA_W-1:0] sdrc_data_out,
  output logic              sdrc_wr_n,
  output logic              sdrc_rd_n,
  output logic [ADDR_W-1:0] sdrc_addr,
  output logic [LEN_W-1:0]  sdrc_data_len,
  output logic [DATA_W-1:0] sdrc_data
);

  localparam int GW = $clog2(GUARD + 2);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_BURST, S_GUARD} state_t;

  state_t           state;
  logic             owner;
  logic             last_gnt;
  logic             wr_lat;
  logic             wreq;
  logic [1:0]       gnt_r;
  logic [1:0]       done_r;
  logic [LEN_W:0]   cnt;
  logic [GW-1:0]    gcnt;
  logic             any_req;
  logic             pick;
  logic             rd_active;
  logic             beat_last;

  // Both requesting: the port that did not win last time goes next.
  always_comb begin
    any_req   = p0_req | p1_req;
    pick      = (p0_req & p1_req) ? ~last_gnt : p1_req;
    rd_active = (state == S_BURST) & ~wr_lat;
    beat_last = (cnt == {1'b0, sdrc_data_len});
  end

  assign p0_gnt       = gnt_r[0];
  assign p1_gnt       = gnt_r[1];
  assign p0_done      = done_r[0];
  assign p1_done      = done_r[1];
  assign p0_wdata_req = wreq & ~owner;
  assign p1_wdata_req = wreq & owner;
  assign p0_rdata     = sdrc_data_out;
  assign p1_rdata     = sdrc_data_out;
  assign p0_rd_valid  = sdrc_rd_valid & rd_active & ~owner;
  assign p1_rd_valid  = sdrc_rd_valid & rd_active & owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      last_gnt      <= 1'b1;
      wr_lat        <= 1'b0;
      wreq          <= 1'b0;
      gnt_r         <= 2'b00;
      done_r        <= 2'b00;
      cnt           <= '0;
      gcnt          <= '0;
      sdrc_wr_n     <= 1'b1;
      sdrc_rd_n     <= 1'b1;
      sdrc_addr     <= '0;
      sdrc_data_len <= '0;
      sdrc_data     <= '0;
    end else begin
      gnt_r     <= 2'b00;
      done_r    <= 2'b00;
      sdrc_wr_n <= 1'b1;
      sdrc_rd_n <= 1'b1;
      // Owner drives a beat the cycle after its request; it is re-registered here.
      if (wr_lat && (state == S_BURST || state == S_GUARD))
        sdrc_data <= owner ? p1_wdata : p0_wdata;
      case (state)
        S_IDLE: begin
          if (sdrc_init_done && sdrc_busy_n && any_req) begin
            owner         <= pick;
            wr_lat        <= pick ? p1_wr : p0_wr;
            sdrc_addr     <= pick ? p1_addr : p0_addr;
            sdrc_data_len <= pick ? p1_len : p0_len;
            sdrc_wr_n     <= ~(pick ? p1_wr : p0_wr);
            sdrc_rd_n     <= pick ? p1_wr : p0_wr;
            gnt_r         <= pick ? 2'b10 : 2'b01;
            state         <= S_CMD;
          end
        end
        S_CMD: begin
          last_gnt <= owner;
          cnt      <= '0;
          wreq     <= wr_lat;
          state    <= S_BURST;
        end
        S_BURST: begin
          if (wr_lat || sdrc_rd_valid) begin
            cnt <= cnt + 1'b1;
            if (beat_last) begin
              wreq  <= 1'b0;
              gcnt  <= '0;
              state <= S_GUARD;
            end
          end
        end
        S_GUARD: begin
          if (gcnt != GW'(GUARD)) begin
            gcnt <= gcnt + 1'b1;
          end else if (sdrc_busy_n) begin
            done_r <= owner ? 2'b10 : 2'b01;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_rr_arbiter.sv
// Directed bench for sdrc_rr_arbiter with a small SDRAM model storing written beats
// and replaying them on reads.
module tb_sdrc_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [20:0] p0_addr, p1_addr;
  logic [7:0]  p0_len, p1_len;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_wdata_req, p0_rd_valid, p0_done;
  logic        p1_gnt, p1_wdata_req, p1_rd_valid, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sdrc_init_done, sdrc_busy_n, sdrc_rd_valid;
  logic [31:0] sdrc_data_out;
  logic        sdrc_wr_n, sdrc_rd_n;
  logic [20:0] sdrc_addr;
  logic [7:0]  sdrc_data_len;
  logic [31:0] sdrc_data;

  sdrc_rr_arbiter #(.ADDR_W(21), .DATA_W(32), .LEN_W(8), .GUARD(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_len(p0_len), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_wdata_req(p0_wdata_req), .p0_rdata(p0_rdata),
    .p0_rd_valid(p0_rd_valid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_len(p1_len), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_wdata_req(p1_wdata_req), .p1_rdata(p1_rdata),
    .p1_rd_valid(p1_rd_valid), .p1_done(p1_done),
    .sdrc_init_done(sdrc_init_done), .sdrc_busy_n(sdrc_busy_n),
    .sdrc_rd_valid(sdrc_rd_valid), .sdrc_data_out(sdrc_data_out),
    .sdrc_wr_n(sdrc_wr_n), .sdrc_rd_n(sdrc_rd_n), .sdrc_addr(sdrc_addr),
    .sdrc_data_len(sdrc_data_len), .sdrc_data(sdrc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor state, written only by the negedge observer.
  int gnt0, gnt1, done0, done1, wr_cnt, rd_cnt, wq0, wq1, rv0, rv1, viol;
  int outstanding, wbase, widx, rbase_cmd;
  logic [7:0]  rlen_cmd;
  logic [20:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        req_d1, req_d2, wreq0_prev, wreq1_prev;
  logic [31:0] wseen[$];
  logic [31:0] rseen0[$];
  logic [31:0] rseen1[$];
  int          glog[$];
  logic [31:0] mem [int];

  initial begin
    gnt0 = 0; gnt1 = 0; done0 = 0; done1 = 0; wr_cnt = 0; rd_cnt = 0;
    wq0 = 0; wq1 = 0; rv0 = 0; rv1 = 0; viol = 0; outstanding = 0;
    wbase = 0; widx = 0; rbase_cmd = 0; rlen_cmd = 0; cmd_addr = 0; cmd_len = 0;
    req_d1 = 0; req_d2 = 0; wreq0_prev = 0; wreq1_prev = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) outstanding = 0;
    if (!sdrc_wr_n || !sdrc_rd_n) begin
      if (outstanding != 0) viol++;
      outstanding = 1;
      cmd_addr = sdrc_addr;
      cmd_len  = sdrc_data_len;
    end
    if (!sdrc_wr_n) begin wr_cnt++; wbase = int'(sdrc_addr); widx = 0; end
    if (!sdrc_rd_n) begin rd_cnt++; rbase_cmd = int'(sdrc_addr); rlen_cmd = sdrc_data_len; end
    if (p0_gnt) begin gnt0++; glog.push_back(0); end
    if (p1_gnt) begin gnt1++; glog.push_back(1); end
    if (p0_done || p1_done) outstanding = 0;
    if (p0_done) done0++;
    if (p1_done) done1++;
    if (req_d2) begin wseen.push_back(sdrc_data); mem[wbase + widx] = sdrc_data; widx++; end
    req_d2 = req_d1;
    req_d1 = p0_wdata_req | p1_wdata_req;
    wreq0_prev = p0_wdata_req;
    wreq1_prev = p1_wdata_req;
    if (p0_wdata_req) wq0++;
    if (p1_wdata_req) wq1++;
    if (p0_rd_valid) begin rv0++; rseen0.push_back(p0_rdata); end
    if (p1_rd_valid) begin rv1++; rseen1.push_back(p1_rdata); end
  end

  function automatic logic [31:0] rd_word(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'(a);
  endfunction

  function automatic int cnt_of(input int id);
    case (id)
      0: return gnt0;
      1: return gnt1;
      2: return done0;
      default: return done1;
    endcase
  endfunction

  // Driver-side model state.
  int seen_gnt0 = 0, seen_gnt1 = 0, seen_rd = 0;
  int wbeat0 = 0, wbeat1 = 0, rleft = 0, rlat = 0, ridx = 0, stray = 0;
  logic [31:0] wpat0 = 0, wpat1 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (gnt0 != seen_gnt0) begin seen_gnt0 = gnt0; wbeat0 = 0; end
    if (gnt1 != seen_gnt1) begin seen_gnt1 = gnt1; wbeat1 = 0; end
    if (wreq0_prev) begin p0_wdata = wpat0 + 32'(wbeat0); wbeat0++; end
    if (wreq1_prev) begin p1_wdata = wpat1 + 32'(wbeat1); wbeat1++; end
    if (rd_cnt != seen_rd) begin seen_rd = rd_cnt; rleft = int'(rlen_cmd) + 1; rlat = 2; ridx = 0; end
    if (rleft > 0 && rlat == 0) begin
      sdrc_rd_valid = 1'b1;
      sdrc_data_out = rd_word(rbase_cmd + ridx);
      ridx++;
      rleft--;
    end else begin
      if (rleft > 0) rlat--;
      sdrc_rd_valid = (stray > 0);
      sdrc_data_out = 32'h5a5a5a5a;
      if (stray > 0) stray--;
    end
  endtask

  task automatic wait_cnt(input int id, input int target, input int bound, input string tag);
    int t = 0;
    while (cnt_of(id) < target && t < bound) begin tick(); t++; end
    check(tag, 64'(cnt_of(id) >= target), 64'd1);
  endtask

  // One complete burst from a single port, with all observable effects checked.
  task automatic burst(input int port, input logic wr, input logic [20:0] addr,
                       input logic [7:0] len, input logic [31:0] pat, input string tag);
    int g, d, od, wc, rc, wq, vq, ov, ws, rs, nbad, n;
    g  = cnt_of(port);
    d  = cnt_of(port + 2);
    od = cnt_of(3 - port);
    wc = wr_cnt; rc = rd_cnt;
    wq = (port == 0) ? wq0 : wq1;
    vq = (port == 0) ? rv0 : rv1;
    ov = (port == 0) ? rv1 : rv0;
    ws = wseen.size();
    rs = (port == 0) ? rseen0.size() : rseen1.size();
    n  = int'(len) + 1;
    if (port == 0) begin p0_wr = wr; p0_addr = addr; p0_len = len; wpat0 = pat; p0_req = 1; end
    else           begin p1_wr = wr; p1_addr = addr; p1_len = len; wpat1 = pat; p1_req = 1; end
    wait_cnt(port, g + 1, 300, {tag, "_gnt"});
    p0_req = 0; p1_req = 0;
    wait_cnt(port + 2, d + 1, 2000, {tag, "_done"});
    check({tag, "_done_other"}, 64'(cnt_of(3 - port) - od), 64'd0);
    check({tag, "_wr_strobes"}, 64'(wr_cnt - wc), wr ? 64'd1 : 64'd0);
    check({tag, "_rd_strobes"}, 64'(rd_cnt - rc), wr ? 64'd0 : 64'd1);
    check({tag, "_addr"}, 64'(cmd_addr), 64'(addr));
    check({tag, "_len"}, 64'(cmd_len), 64'(len));
    nbad = 0;
    if (wr) begin
      check({tag, "_wdata_req_beats"}, 64'(((port == 0) ? wq0 : wq1) - wq), 64'(n));
      for (int k = 0; k < n; k++)
        if (ws + k >= wseen.size() || wseen[ws + k] !== pat + 32'(k)) nbad++;
    end else begin
      check({tag, "_rd_valid_beats"}, 64'(((port == 0) ? rv0 : rv1) - vq), 64'(n));
      check({tag, "_rd_valid_other"}, 64'(((port == 0) ? rv1 : rv0) - ov), 64'd0);
      for (int k = 0; k < n; k++) begin
        if (port == 0) begin
          if (rs + k >= rseen0.size() || rseen0[rs + k] !== pat + 32'(k)) nbad++;
        end else begin
          if (rs + k >= rseen1.size() || rseen1[rs + k] !== pat + 32'(k)) nbad++;
        end
      end
    end
    check({tag, "_data_bad_beats"}, 64'(nbad), 64'd0);
  endtask

  initial begin
    int g0, g1, d0, d1, rc, wc, v0, v1, gs, t;
    rst_n = 0; p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
    p0_addr = 0; p1_addr = 0; p0_len = 0; p1_len = 0; p0_wdata = 0; p1_wdata = 0;
    sdrc_init_done = 0; sdrc_busy_n = 1; sdrc_rd_valid = 0; sdrc_data_out = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {sdrc_wr_n, sdrc_rd_n}, 2'b11);
    check("rst_addr", sdrc_addr, 0);
    check("rst_len", sdrc_data_len, 0);
    check("rst_data", sdrc_data, 0);
    check("rst_port_outs", {p0_gnt, p1_gnt, p0_wdata_req, p1_wdata_req, p0_done, p1_done}, 0);
    rst_n = 1;

    // Controller not initialised: request must not be served, then is withdrawn.
    p0_wr = 1; p0_addr = 21'h000123; p0_len = 0; p0_req = 1;
    repeat (20) tick();
    check("noinit_strobes", 64'(wr_cnt + rd_cnt), 0);
    check("noinit_gnt", 64'(gnt0 + gnt1), 0);
    p0_req = 0;
    sdrc_init_done = 1;
    repeat (5) tick();
    check("dropped_req_gnt", 64'(gnt0 + gnt1), 0);

    burst(0, 1'b1, 21'h080205, 8'd25, 32'd0, "p0_wr26");
    burst(1, 1'b0, 21'h080205, 8'd25, 32'd0, "p1_rd26");

    // Read-valid outside a read burst is ignored.
    v0 = rv0; v1 = rv1;
    stray = 4;
    repeat (8) tick();
    check("stray_rd_valid", 64'((rv0 - v0) + (rv1 - v1)), 0);

    // Both ports requesting continuously: strict alternation.
    gs = glog.size(); d0 = done0; d1 = done1;
    p0_wr = 1; p0_addr = 21'h000040; p0_len = 3; wpat0 = 32'h100;
    p1_wr = 0; p1_addr = 21'h080205; p1_len = 3;
    p0_req = 1; p1_req = 1;
    t = 0;
    while (glog.size() < gs + 4 && t < 500) begin tick(); t++; end
    p0_req = 0; p1_req = 0;
    check("alt_four_grants", 64'(glog.size() >= gs + 4), 1);
    wait_cnt(2, d0 + 2, 200, "alt_done0");
    wait_cnt(3, d1 + 2, 200, "alt_done1");
    if (glog.size() >= gs + 4)
      check("alt_order", {glog[gs][0], glog[gs+1][0], glog[gs+2][0], glog[gs+3][0]}, 4'b0101);

    // busy_n low after the burst holds off done and the next command.
    d0 = done0; rc = rd_cnt;
    p0_wr = 1; p0_addr = 21'h000600; p0_len = 2; wpat0 = 32'h600; p0_req = 1;
    wait_cnt(0, gnt0 + 1, 100, "busy_gnt0");
    sdrc_busy_n = 0; p0_req = 0;
    p1_wr = 0; p1_addr = 21'h000600; p1_len = 0; p1_req = 1;
    v1 = rv1;
    repeat (50) tick();
    check("busy_no_done", 64'(done0 - d0), 0);
    check("busy_no_cmd", 64'(rd_cnt - rc), 0);
    sdrc_busy_n = 1;
    wait_cnt(2, d0 + 1, 20, "busy_done0");
    wait_cnt(1, gnt1 + 1, 20, "busy_gnt1");
    p1_req = 0;
    wait_cnt(3, done1 + 1, 50, "busy_done1");
    check("busy_p1_rd_beat", 64'(rv1 - v1), 1);

    burst(0, 1'b1, 21'h000100, 8'd0, 32'h40, "len0_wr");
    burst(1, 1'b1, 21'h000200, 8'd255, 32'h1000, "len255_wr");
    burst(0, 1'b0, 21'h000200, 8'd255, 32'h1000, "len255_rd");

    // Asynchronous reset in the middle of a p0 write burst.
    d0 = done0; d1 = done1;
    p0_wr = 1; p0_addr = 21'h000300; p0_len = 20; wpat0 = 32'h300; p0_req = 1;
    wait_cnt(0, gnt0 + 1, 100, "mrst_gnt0");
    p0_req = 0;
    repeat (5) tick();
    rst_n = 0;
    #1;
    check("mrst_strobes", {sdrc_wr_n, sdrc_rd_n}, 2'b11);
    check("mrst_wdata_req", {p0_wdata_req, p1_wdata_req}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) tick();
    check("mrst_no_done", 64'((done0 - d0) + (done1 - d1)), 0);
    gs = glog.size();
    p0_wr = 1; p0_addr = 21'h000400; p0_len = 1; wpat0 = 32'h400;
    p1_wr = 1; p1_addr = 21'h000500; p1_len = 1; wpat1 = 32'h500;
    p0_req = 1; p1_req = 1;
    t = 0;
    while (glog.size() <= gs && t < 100) begin tick(); t++; end
    check("mrst_first_gnt_seen", 64'(glog.size() > gs), 1);
    if (glog.size() > gs) check("mrst_first_gnt_port", 64'(glog[gs]), 0);
    p0_req = 0;
    wait_cnt(2, done0 + 1, 100, "mrst_done0");
    wait_cnt(1, gnt1 + 1, 50, "mrst_gnt1");
    p1_req = 0;
    wait_cnt(3, done1 + 1, 100, "mrst_done1");

    check("one_cmd_per_done", 64'(viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
